// File: rtl/chargen_arbiter.sv
// chargen_arbiter
//
// Owns the single-port 1K x GLYPH_W character-generator RAM. Each clock it
// grants the RAM slot to one user. The video fetch path always wins. The host
// font-load/readback port gets the slot only when video is idle and no host
// operation is in flight. The RAM controls (ram_*) are registered.
//
// A tag pipeline of RD_LAT stages records who owns each read. When a tag
// reaches the last stage, ram_dout is routed to its owner. Video data loads
// the pixel shifter, and host data goes to host_rdata together with a
// host_ack pulse.
//
// RD_LAT counts clocks from the edge that registers the slot onto ram_* to
// the edge that captures ram_dout. It must match how the RAM is configured.
// Legal values are 1..3.
//
// Optional build macro: CHARGEN_INVERSE_EN. When it is defined, vid_char[7]
// rides in the tags, and a set bit loads the inverted glyph row.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   vid_req/vid_char/vid_row   one-cycle video glyph-row fetch
//   pix_en, pix_out            pixel shifter enable and serial pixel (MSB first)
//   vid_miss                   sticky: fetch requested while one was in flight
//   host_req/we/addr/wdata     host request, held until host_ack
//   host_ack, host_rdata       one-cycle completion, read data
//   ram_ad/din/wre/ce/oce      RAM controls
//   ram_dout                   RAM read data
module chargen_arbiter #(
    parameter int RD_LAT  = 2,
    parameter int GLYPH_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vid_req,
    input  logic [7:0]         vid_char,
    input  logic [2:0]         vid_row,
    input  logic               pix_en,
    output logic               pix_out,
    output logic               vid_miss,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [9:0]         host_addr,
    input  logic [GLYPH_W-1:0] host_wdata,
    output logic               host_ack,
    output logic [GLYPH_W-1:0] host_rdata,
    output logic [9:0]         ram_ad,
    output logic [GLYPH_W-1:0] ram_din,
    output logic               ram_wre,
    output logic               ram_ce,
    output logic               ram_oce,
    input  logic [GLYPH_W-1:0] ram_dout
);

    logic [RD_LAT-1:0]  tag_vld;
    logic [RD_LAT-1:0]  tag_host;
`ifdef CHARGEN_INVERSE_EN
    logic [RD_LAT-1:0]  tag_inv;
`else
    logic               unused_inv;
    assign unused_inv = vid_char[7];
`endif
    logic [GLYPH_W-1:0] shift_q;

    logic               vid_busy;
    logic               host_busy;
    logic               grant_vid;
    logic               grant_host;
    logic               ret_vid;
    logic               ret_host;
    logic [GLYPH_W-1:0] glyph;

    always_comb begin
        vid_busy   = |(tag_vld & ~tag_host);
        // host_ack is included so a request still held during the ack cycle
        // cannot start a second operation.
        host_busy  = host_ack | (|(tag_vld & tag_host));
        grant_vid  = vid_req;
        grant_host = ~vid_req & host_req & ~host_busy;
        ret_vid    = tag_vld[RD_LAT-1] & ~tag_host[RD_LAT-1];
        ret_host   = tag_vld[RD_LAT-1] & tag_host[RD_LAT-1];
        glyph      = ram_dout;
`ifdef CHARGEN_INVERSE_EN
        if (tag_inv[RD_LAT-1]) begin
            glyph = ~ram_dout;
        end
`endif
    end

    // Only reads enter the tag pipeline. Host writes complete on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld  <= '0;
            tag_host <= '0;
`ifdef CHARGEN_INVERSE_EN
            tag_inv  <= '0;
`endif
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_host[i] <= tag_host[i-1];
`ifdef CHARGEN_INVERSE_EN
                tag_inv[i]  <= tag_inv[i-1];
`endif
            end
            tag_vld[0]  <= grant_vid | (grant_host & ~host_we);
            tag_host[0] <= grant_host & ~host_we;
`ifdef CHARGEN_INVERSE_EN
            tag_inv[0]  <= grant_vid & vid_char[7];
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_ad  <= '0;
            ram_din <= '0;
            ram_wre <= 1'b0;
            ram_ce  <= 1'b0;
        end else if (grant_vid) begin
            ram_ad  <= {vid_char[6:0], vid_row};
            ram_wre <= 1'b0;
            ram_ce  <= 1'b1;
        end else if (grant_host) begin
            ram_ad  <= host_addr;
            ram_din <= host_wdata;
            ram_wre <= host_we;
            ram_ce  <= 1'b1;
        end else begin
            ram_wre <= 1'b0;
            ram_ce  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_ack   <= 1'b0;
            host_rdata <= '0;
        end else begin
            host_ack <= (grant_host & host_we) | ret_host;
            if (ret_host) begin
                host_rdata <= ram_dout;
            end
        end
    end

    // A load takes priority over a shift in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            vid_miss <= 1'b0;
        end else begin
            vid_miss <= vid_miss | (vid_req & vid_busy);
            if (ret_vid) begin
                shift_q <= glyph;
            end else if (pix_en) begin
                shift_q <= {shift_q[GLYPH_W-2:0], 1'b0};
            end
        end
    end

    assign pix_out = shift_q[GLYPH_W-1];
    assign ram_oce = 1'b1;

endmodule

// File: doc/chargen_arbiter.md
Name: chargen_arbiter

Overview:
- Owns the single-port 1K x 6 character-generator RAM. Shares it between the video fetch path (real-time, highest priority) and a host font-load/readback port.
- Tracks the RAM's registered-output read latency and routes returned data to its owner.
- Serialises video glyph rows into a pixel stream for the Model III video timing block.

Parameters:
- RD_LAT, 2, RAM read latency in clocks (pipelined output register mode); legal values 1..3.
- GLYPH_W, 6, RAM data width and pixels per character cell.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- vid_req  in  1  one-cycle fetch strobe, once per character cell
- vid_char  in  8  character code; [6:0] selects glyph, [7] is the inverse flag (optional feature)
- vid_row  in  3  scanline within the glyph
- pix_en  in  1  pixel-clock enable; advances the shifter
- pix_out  out  1  current pixel, MSB of the glyph first
- vid_miss  out  1  sticky flag: vid_req arrived while a video fetch was still in flight
- host_req  in  1  level request; hold until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  10  {char[6:0], row[2:0]}
- host_wdata  in  GLYPH_W  write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  GLYPH_W  read data, valid when host_ack is high on a read
- ram_ad  out  10  RAM address
- ram_din  out  GLYPH_W  RAM write data
- ram_wre  out  1  RAM write enable
- ram_ce  out  1  RAM clock enable
- ram_oce  out  1  RAM output-register enable; tied high
- ram_dout  in  GLYPH_W  RAM read data

Behaviour:
- Reset values (async): pix_out 0, vid_miss 0, host_ack 0, host_rdata 0, ram_wre 0, ram_ce 0, ram_ad 0, ram_din 0. Shifter and tag pipeline are cleared.
- Slot grant, every clock, combinational to registered RAM controls:
  - If vid_req is high, issue a video read: ram_ad = {vid_char[6:0], vid_row}, ram_ce = 1, ram_wre = 0.
  - Otherwise, if host_req is high and no host operation is in flight, issue the host operation: ram_ad = host_addr, ram_ce = 1, ram_wre = host_we, ram_din = host_wdata.
  - Otherwise ram_ce = 0.
- Video always wins. A host request is deferred while vid_req is high, with no timeout.
- Tag pipeline: RD_LAT stages. Each stage holds {valid, owner, inv}, so video and host reads may interleave back to back.
- Host write: host_ack pulses in the cycle after the write slot is issued.
- Host read: host_ack pulses and host_rdata is captured in the cycle RD_LAT clocks after the slot. Only one host operation is outstanding at a time; host_req sampled during that window is ignored.
- host_req must be held until host_ack; dropping it early has undefined effect on an already-issued slot.
- Video return, RD_LAT clocks after vid_req:
  - The shifter loads ram_dout, masked to GLYPH_W bits.
  - pix_out shows bit GLYPH_W-1 immediately after the load.
  - Each pix_en shifts left by one, filling with 0. After GLYPH_W shifts pix_out holds 0.
  - If a load and pix_en occur in the same cycle, the load wins and no shift happens.
- vid_miss: set if vid_req is asserted while an earlier video tag is still in the pipeline. Cleared only by reset.
- Reset mid-read: all in-flight tags are dropped and no host_ack is issued. The host must re-request.

Optional Feature:
- Macro: CHARGEN_INVERSE_EN.
- With the macro defined: vid_char[7] travels down the tag pipeline; when it is set, the shifter loads the bitwise NOT of ram_dout[GLYPH_W-1:0].
- Without the macro: vid_char[7] is ignored and no inverse bit is stored in the tags.

Test Plan:
- RAM model preloaded with the production font. vid_req, vid_char = 0x41, vid_row = 0 -> ram_ad = 0x208; 2 clocks later the shifter holds 0x04; six pix_en pulses give pix_out 0,0,0,1,0,0.
- vid_char = 0x41, vid_row = 4 -> glyph 0x1F; pix_out 0,1,1,1,1,1. Repeat with vid_char = 0xC1 under CHARGEN_INVERSE_EN -> 1,0,0,0,0,0.
- Host write addr 0x208, data 0x2A, issued while vid_req is high for 3 cycles -> write deferred 3 cycles, host_ack 1 cycle after the slot. A later video fetch of 0x41 row 0 returns 0x2A.
- Host read addr 0x20C in the cycle after a video fetch -> both tags in flight; the shifter gets the video glyph, host_ack and host_rdata = 0x1F arrive one cycle later, with no cross-routing.
- Two vid_req on consecutive clocks -> vid_miss = 1, and it stays set until reset.
- Assert reset one cycle after a host read is issued -> no host_ack, all outputs at reset values. A re-issued read completes normally.
